conm_soc_top: RTL and testbench

- Minimal RV32I system-on-chip: single-cycle integer core plus one unified byte-addressed memory holding both program and data.
- Top-level simulation/integration block; the only external pins are clock and reset.
- Benches preload the memory with a hex image and inspect the register file through fixed hierarchical names.

---
 rtl/conm_soc_top.sv | 255 +++++++++++++++++++++++++
 tb/tb_conm_soc_top.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conm_soc_top.sv
// conm_soc_top: minimal RV32I SoC, a single-cycle core sharing one byte-addressed memory.
// Optional build macro CONM_ECALL_HALT_EN: ECALL/EBREAK halt the core until reset.

module conm_mem #(
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic        clk_i,
  input  logic [31:0] iaddr_i,
  output logic [31:0] irdata_o,
  input  logic [31:0] daddr_i,
  output logic [31:0] drdata_o,
  input  logic [31:0] dwdata_i,
  input  logic [3:0]  dbe_i
);
  localparam int unsigned AW = $clog2(MEM_BYTES);

  logic [7:0] mem_unit [0:MEM_BYTES-1];

  // Byte lanes are assembled individually so misaligned accesses wrap modulo MEM_BYTES.
  for (genvar k = 0; k < 4; k++) begin : g_byte
    logic [AW-1:0] iidx, didx;
    assign iidx = iaddr_i[AW-1:0] + AW'(k);
    assign didx = daddr_i[AW-1:0] + AW'(k);
    assign irdata_o[8*k +: 8] = mem_unit[iidx];
    assign drdata_o[8*k +: 8] = mem_unit[didx];
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (dbe_i[k]) mem_unit[daddr_i[AW-1:0] + AW'(k)] <= dwdata_i[8*k +: 8];
    end
  end

  logic unused_addr;
  assign unused_addr = ^{iaddr_i[31:AW], daddr_i[31:AW]};
endmodule

module conm_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs[raddr2_i];
endmodule

module conm_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] iaddr_o,
  input  logic [31:0] instr_i,
  output logic [31:0] daddr_o,
  input  logic [31:0] drdata_i,
  output logic [31:0] dwdata_o,
  output logic [3:0]  dbe_o
);
  localparam logic [6:0] OpLui = 7'b0110111, OpAuipc = 7'b0010111, OpJal = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111, OpBranch = 7'b1100011, OpLoad = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011, OpImm = 7'b0010011, OpReg = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic [31:0] pc_q, pc_d, pc_next;
  logic [31:0] rs1_data, rs2_data, rd_wdata;
  logic        rd_we, taken, stall;
  logic [3:0]  st_be;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'h000};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21],
                   1'b0};

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    logic [31:0] r;
    case (f3)
      3'b000:  r = alt ? a - b : a + b;
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'b0, $signed(a) < $signed(b)};
      3'b011:  r = {31'b0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  conm_regfile u_csregfile (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .raddr1_i (instr_i[19:15]),
    .raddr2_i (instr_i[24:20]),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data),
    .we_i     (rd_we & ~stall),
    .waddr_i  (instr_i[11:7]),
    .wdata_i  (rd_wdata)
  );

  always_comb begin
    pc_next  = pc_q + 32'd4;
    rd_we    = 1'b0;
    rd_wdata = '0;
    st_be    = '0;
    taken    = 1'b0;
    case (opcode)
      OpLui:   begin rd_we = 1'b1; rd_wdata = imm_u; end
      OpAuipc: begin rd_we = 1'b1; rd_wdata = pc_q + imm_u; end
      OpJal: begin
        rd_we = 1'b1; rd_wdata = pc_q + 32'd4;
        pc_next = (pc_q + imm_j) & ~32'd1;
      end
      OpJalr: begin
        rd_we = 1'b1; rd_wdata = pc_q + 32'd4;
        pc_next = (rs1_data + imm_i) & ~32'd1;
      end
      OpBranch: begin
        case (funct3)
          3'b000:  taken = (rs1_data == rs2_data);
          3'b001:  taken = (rs1_data != rs2_data);
          3'b100:  taken = ($signed(rs1_data) < $signed(rs2_data));
          3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
          3'b110:  taken = (rs1_data < rs2_data);
          3'b111:  taken = (rs1_data >= rs2_data);
          default: taken = 1'b0;
        endcase
        if (taken) pc_next = (pc_q + imm_b) & ~32'd1;
      end
      OpLoad: begin
        rd_we = 1'b1;
        case (funct3)
          3'b000:  rd_wdata = {{24{drdata_i[7]}}, drdata_i[7:0]};
          3'b001:  rd_wdata = {{16{drdata_i[15]}}, drdata_i[15:0]};
          3'b010:  rd_wdata = drdata_i;
          3'b100:  rd_wdata = {24'b0, drdata_i[7:0]};
          3'b101:  rd_wdata = {16'b0, drdata_i[15:0]};
          default: rd_we = 1'b0;
        endcase
      end
      OpStore: begin
        case (funct3)
          3'b000:  st_be = 4'b0001;
          3'b001:  st_be = 4'b0011;
          3'b010:  st_be = 4'b1111;
          default: st_be = 4'b0000;
        endcase
      end
      OpImm: begin
        rd_we = 1'b1;
        rd_wdata = alu(rs1_data, imm_i, funct3, (funct3 == 3'b101) && instr_i[30]);
      end
      OpReg: begin
        // Only funct7 of 0, or 0x20 for SUB/SRA, is a real instruction.
        if ((instr_i[31:25] == 7'b0) ||
            ((instr_i[31:25] == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          rd_we = 1'b1;
          rd_wdata = alu(rs1_data, rs2_data, funct3, instr_i[30]);
        end
      end
      OpSystem: begin
        if (funct3 != 3'b000) rd_we = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CONM_ECALL_HALT_EN
  logic halted, halt_req;
  assign halt_req = (instr_i == 32'h0000_0073) || (instr_i == 32'h0010_0073);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) halted <= 1'b0;
    else         halted <= halted | halt_req;
  end

  assign stall = halted | halt_req;
`else
  assign stall = 1'b0;
`endif

  assign pc_d = stall ? pc_q : pc_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  assign iaddr_o  = pc_q;
  assign daddr_o  = rs1_data + ((opcode == OpStore) ? imm_s : imm_i);
  assign dwdata_o = rs2_data;
  // A store coinciding with reset assertion is dropped.
  assign dbe_o    = st_be & {4{rst_ni & ~stall}};
endmodule

module conm_soc_top #(
  parameter int unsigned MEM_BYTES = 16384,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  logic [31:0] iaddr, irdata, daddr, drdata, dwdata;
  logic [3:0]  dbe;

  conm_mem #(
    .MEM_BYTES (MEM_BYTES)
  ) imem (
    .clk_i    (clk),
    .iaddr_i  (iaddr),
    .irdata_o (irdata),
    .daddr_i  (daddr),
    .drdata_o (drdata),
    .dwdata_i (dwdata),
    .dbe_i    (dbe)
  );

  conm_core #(
    .RESET_PC (RESET_PC)
  ) u_CoNM (
    .clk_i    (clk),
    .rst_ni   (rst),
    .iaddr_o  (iaddr),
    .instr_i  (irdata),
    .daddr_o  (daddr),
    .drdata_i (drdata),
    .dwdata_o (dwdata),
    .dbe_o    (dbe)
  );
endmodule

// File: tb/tb_conm_soc_top.sv
// Bench for conm_soc_top: directed programs with fixed expectations plus random programs
// checked against an instruction-level model of the RV32I subset.

module tb_conm_soc_top;
  localparam int MB = 16384;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  conm_soc_top #(.MEM_BYTES(MB), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst));

  int checks = 0;
  int errors = 0;
  logic [31:0] prog[$];
  logic [7:0]  mmem [0:MB-1];
  logic [31:0] mreg [0:31];
  logic [31:0] mpc;

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd,
                                        input int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3,
                                        input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] enc_u(input int imm, input int rd, input int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction

  // Zero-time: clear both memories, place prog at 0, reset the model state.
  task automatic load_prog();
    for (int i = 0; i < MB; i++) begin
      dut.imem.mem_unit[i] = 8'h00;
      mmem[i] = 8'h00;
    end
    foreach (prog[w]) begin
      for (int b = 0; b < 4; b++) begin
        dut.imem.mem_unit[4*w+b] = prog[w][8*b +: 8];
        mmem[4*w+b] = prog[w][8*b +: 8];
      end
    end
    for (int r = 0; r < 32; r++) mreg[r] = '0;
    mpc = '0;
  endtask

  task automatic reset_load();
    rst = 1'b0;
    @(negedge clk);
    load_prog();
  endtask

  task automatic start(input int ncyc);
    @(negedge clk);
    rst = 1'b1;
    repeat (ncyc) @(negedge clk);
  endtask

  // Instruction-level reference: one architectural step of the model machine.
  task automatic iss_step();
    logic [31:0] ins, a, b, res, addr, ld, nxt;
    logic        wr;
    ins = {mmem[(mpc+3)%MB], mmem[(mpc+2)%MB], mmem[(mpc+1)%MB], mmem[mpc%MB]};
    a = mreg[ins[19:15]];
    b = mreg[ins[24:20]];
    wr = 1'b0; res = '0; nxt = mpc + 4;
    case (ins[6:0])
      7'h37: begin wr = 1'b1; res = {ins[31:12], 12'h000}; end
      7'h17: begin wr = 1'b1; res = mpc + {ins[31:12], 12'h000}; end
      7'h6f: begin
        wr = 1'b1; res = mpc + 4;
        nxt = mpc + 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'h13, 7'h33: begin
        if (ins[6:0] == 7'h13) b = 32'($signed(ins[31:20]));
        wr = 1'b1;
        case (ins[14:12])
          3'd0: res = (ins[6:0] == 7'h33 && ins[30]) ? a - b : a + b;
          3'd1: res = a << b[4:0];
          3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: res = (a < b) ? 32'd1 : 32'd0;
          3'd4: res = a ^ b;
          3'd5: res = ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: res = a | b;
          default: res = a & b;
        endcase
      end
      7'h03: begin
        addr = a + 32'($signed(ins[31:20]));
        ld = {mmem[(addr+3)%MB], mmem[(addr+2)%MB], mmem[(addr+1)%MB], mmem[addr%MB]};
        wr = 1'b1;
        case (ins[14:12])
          3'd0: res = 32'($signed(ld[7:0]));
          3'd1: res = 32'($signed(ld[15:0]));
          3'd2: res = ld;
          3'd4: res = {24'h0, ld[7:0]};
          3'd5: res = {16'h0, ld[15:0]};
          default: wr = 1'b0;
        endcase
      end
      7'h23: begin
        addr = a + 32'($signed({ins[31:25], ins[11:7]}));
        for (int i = 0; i < (1 << ins[13:12]); i++) mmem[(addr+i)%MB] = b[8*i +: 8];
      end
      default: ;
    endcase
    if (wr && ins[11:7] != 5'd0) mreg[ins[11:7]] = res;
    mpc = nxt;
  endtask

  function automatic logic [31:0] gen_rand();
    int kind, f3, rd, rs1, rs2, imm;
    kind = $urandom_range(0, 9);
    f3 = $urandom_range(0, 7);
    rd = $urandom_range(1, 30);
    rs1 = $urandom_range(0, 31);
    rs2 = $urandom_range(0, 31);
    imm = $urandom_range(0, 4095);
    if (kind <= 3) begin
      if (f3 == 1) imm = imm % 32;
      if (f3 == 5) imm = (imm % 32) | ($urandom_range(0, 1) ? 32'h400 : 32'h0);
      return enc_i(imm, rs1, f3, rd, 7'h13);
    end else if (kind <= 6) begin
      return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1)) ? 32 : 0, rs2, rs1, f3, rd);
    end else if (kind == 7) begin
      return enc_u($urandom_range(0, 20'hfffff), rd, $urandom_range(0, 1) ? 7'h37 : 7'h17);
    end else if (kind == 8) begin
      f3 = $urandom_range(0, 4);
      if (f3 == 3) f3 = 5;
      return enc_i($urandom_range(0, 63), 31, f3, rd, 7'h03);
    end
    return enc_s($urandom_range(0, 63), rs2, 31, $urandom_range(0, 2));
  endfunction

  task automatic test_reset();
    int bad;
    prog = {enc_i(1, 0, 0, 3, 7'h13), enc_j(0, 0)};
    load_prog();
    #35;
    if (dut.u_CoNM.pc_q !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h want 00000000", dut.u_CoNM.pc_q);
    end
    checks++;
    bad = 0;
    for (int r = 1; r < 32; r++) if (dut.u_CoNM.u_csregfile.regs[r] !== 32'h0) bad++;
    if (bad !== 0) begin errors++; $display("FAIL reset_regs: %0d nonzero want 0", bad); end
    checks++;
    #5 rst = 1'b1;
    #20;
    if (dut.u_CoNM.u_csregfile.regs[3] !== 32'h1 || dut.u_CoNM.pc_q !== 32'h4) begin
      errors++; $display("FAIL first_retire: x3=%h pc=%h want 1/4",
                         dut.u_CoNM.u_csregfile.regs[3], dut.u_CoNM.pc_q);
    end
    checks++;
  endtask

  task automatic test_addi();
    prog = {enc_i(1, 0, 0, 3, 7'h13), enc_i(-2, 3, 0, 5, 7'h13), enc_j(0, 0)};
    reset_load();
    start(3);
    if (dut.u_CoNM.u_csregfile.regs[3] !== 32'h1) begin
      errors++; $display("FAIL addi_x3: got %h want 1", dut.u_CoNM.u_csregfile.regs[3]);
    end
    checks++;
    if (dut.u_CoNM.u_csregfile.regs[5] !== 32'hffff_ffff) begin
      errors++; $display("FAIL addi_x5: got %h want ffffffff", dut.u_CoNM.u_csregfile.regs[5]);
    end
    checks++;
    repeat (4) @(negedge clk);
    if (dut.u_CoNM.pc_q !== 32'h8) begin
      errors++; $display("FAIL jal_self: pc got %h want 8", dut.u_CoNM.pc_q);
    end
    checks++;
  endtask

  task automatic test_ldst();
    prog = {enc_u(1, 1, 7'h37), enc_i(12'h80, 0, 0, 2, 7'h13), enc_s(1, 2, 1, 0),
            enc_i(1, 1, 0, 4, 7'h03), enc_i(1, 1, 4, 6, 7'h03), enc_i(0, 1, 2, 7, 7'h03),
            enc_j(0, 0)};
    reset_load();
    start(8);
    if (dut.u_CoNM.u_csregfile.regs[4] !== 32'hffff_ff80) begin
      errors++; $display("FAIL lb: got %h want ffffff80", dut.u_CoNM.u_csregfile.regs[4]);
    end
    checks++;
    if (dut.u_CoNM.u_csregfile.regs[6] !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu: got %h want 00000080", dut.u_CoNM.u_csregfile.regs[6]);
    end
    checks++;
    if (dut.u_CoNM.u_csregfile.regs[7] !== 32'h0000_8000) begin
      errors++; $display("FAIL lw: got %h want 00008000", dut.u_CoNM.u_csregfile.regs[7]);
    end
    checks++;
  endtask

  task automatic test_wrap();
    prog = {enc_u(20'h12345, 8, 7'h37), enc_i(12'h678, 8, 0, 8, 7'h13),
            enc_u(20'h80004, 1, 7'h37), enc_i(-2, 1, 0, 1, 7'h13), enc_s(0, 8, 1, 2),
            enc_i(0, 1, 2, 9, 7'h03), enc_i(0, 0, 4, 11, 7'h03), enc_i(1, 1, 5, 13, 7'h03),
            enc_j(0, 0)};
    reset_load();
    start(10);
    if (dut.u_CoNM.u_csregfile.regs[9] !== 32'h1234_5678) begin
      errors++; $display("FAIL wrap_lw: got %h want 12345678", dut.u_CoNM.u_csregfile.regs[9]);
    end
    checks++;
    if (dut.u_CoNM.u_csregfile.regs[11] !== 32'h34) begin
      errors++; $display("FAIL wrap_lbu: got %h want 34", dut.u_CoNM.u_csregfile.regs[11]);
    end
    checks++;
    if (dut.u_CoNM.u_csregfile.regs[13] !== 32'h3456) begin
      errors++; $display("FAIL wrap_lhu: got %h want 3456", dut.u_CoNM.u_csregfile.regs[13]);
    end
    checks++;
  endtask

  task automatic test_branch();
    prog = {enc_i(-1, 0, 0, 5, 7'h13), enc_b(8, 0, 0, 1), enc_i(7, 0, 0, 20, 7'h13),
            enc_b(8, 0, 5, 4), enc_j(0, 0), enc_i(12'h11, 0, 0, 1, 7'h67)};
    reset_load();
    start(7);
    if (dut.u_CoNM.u_csregfile.regs[20] !== 32'h7) begin
      errors++; $display("FAIL bne_not_taken: x20 got %h want 7",
                         dut.u_CoNM.u_csregfile.regs[20]);
    end
    checks++;
    if (dut.u_CoNM.u_csregfile.regs[1] !== 32'h18) begin
      errors++; $display("FAIL jalr_link: x1 got %h want 18", dut.u_CoNM.u_csregfile.regs[1]);
    end
    checks++;
    if (dut.u_CoNM.pc_q !== 32'h10) begin
      errors++; $display("FAIL jalr_target: pc got %h want 10", dut.u_CoNM.pc_q);
    end
    checks++;
  endtask

  task automatic test_x0_csr();
    prog = {enc_i(5, 0, 0, 0, 7'h13), enc_i(3, 0, 0, 10, 7'h13), enc_i(12'hf14, 0, 2, 10, 7'h73),
            32'h0ff0_000f, 32'hffff_ffff, enc_i(1, 0, 0, 12, 7'h13), enc_j(0, 0)};
    reset_load();
    start(8);
    if (dut.u_CoNM.u_csregfile.regs[0] !== 32'h0) begin
      errors++; $display("FAIL x0_write: got %h want 0", dut.u_CoNM.u_csregfile.regs[0]);
    end
    checks++;
    if (dut.u_CoNM.u_csregfile.regs[10] !== 32'h0) begin
      errors++; $display("FAIL csrr: x10 got %h want 0", dut.u_CoNM.u_csregfile.regs[10]);
    end
    checks++;
    if (dut.u_CoNM.u_csregfile.regs[12] !== 32'h1 || dut.u_CoNM.pc_q !== 32'h18) begin
      errors++; $display("FAIL fence_illegal_nop: x12=%h pc=%h want 1/18",
                         dut.u_CoNM.u_csregfile.regs[12], dut.u_CoNM.pc_q);
    end
    checks++;
  endtask

  task automatic test_ecall();
    logic [31:0] want_x3, want_pc;
    prog = {enc_i(1, 0, 0, 3, 7'h13), 32'h0000_0073, enc_i(2, 0, 0, 3, 7'h13), enc_j(0, 0)};
`ifdef CONM_ECALL_HALT_EN
    want_x3 = 32'h1; want_pc = 32'h4;
`else
    want_x3 = 32'h2; want_pc = 32'hc;
`endif
    reset_load();
    start(10);
    if (dut.u_CoNM.u_csregfile.regs[3] !== want_x3 || dut.u_CoNM.pc_q !== want_pc) begin
      errors++; $display("FAIL ecall: x3=%h pc=%h want %h/%h",
                         dut.u_CoNM.u_csregfile.regs[3], dut.u_CoNM.pc_q, want_x3, want_pc);
    end
    checks++;
  endtask

  task automatic test_midreset();
    prog = {enc_i(12'h55, 0, 0, 2, 7'h13), enc_u(1, 1, 7'h37), enc_s(0, 2, 1, 0), enc_j(0, 0)};
    reset_load();
    start(2);
    rst = 1'b0;
    #1;
    if (dut.u_CoNM.pc_q !== 32'h0 || dut.u_CoNM.u_csregfile.regs[2] !== 32'h0) begin
      errors++; $display("FAIL async_reset: pc=%h x2=%h want 0/0",
                         dut.u_CoNM.pc_q, dut.u_CoNM.u_csregfile.regs[2]);
    end
    checks++;
    @(negedge clk);
    if (dut.imem.mem_unit[16'h1000] !== 8'h00) begin
      errors++; $display("FAIL store_dropped: got %h want 00", dut.imem.mem_unit[16'h1000]);
    end
    checks++;
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(10, 40);
      prog = {enc_u(2, 31, 7'h37)};
      for (int i = 0; i < n; i++) prog.push_back(gen_rand());
      prog.push_back(enc_j(0, 0));
      reset_load();
      for (int a = 16'h2000; a < 16'h2048; a++) begin
        mmem[a] = 8'($urandom);
        dut.imem.mem_unit[a] = mmem[a];
      end
      start(n + 3);
      for (int s = 0; s < n + 3; s++) iss_step();
      for (int r = 1; r < 32; r++) begin
        if (dut.u_CoNM.u_csregfile.regs[r] !== mreg[r]) begin
          errors++; $display("FAIL rand%0d_x%0d: got %h want %h", t, r,
                             dut.u_CoNM.u_csregfile.regs[r], mreg[r]);
        end
        checks++;
      end
      if (dut.u_CoNM.pc_q !== mpc) begin
        errors++; $display("FAIL rand%0d_pc: got %h want %h", t, dut.u_CoNM.pc_q, mpc);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_ldst();
    test_wrap();
    test_branch();
    test_x0_csr();
    test_ecall();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
